// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates entries at dispatch, captures writeback
// results, and retires up to RETIRE_WIDTH consecutive completed entries per cycle.
module reorder_buffer #(
  parameter int ROB_DEPTH    = 32,
  parameter int RETIRE_WIDTH = 2,
  parameter int NUM_AREGS    = 32,
  parameter int WB_PORTS     = 2,
  parameter int TAG_W        = $clog2(ROB_DEPTH),
  localparam int AREG_W      = $clog2(NUM_AREGS),
  localparam int CNT_W       = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_n_i,
  input  logic                                    disp_valid_i,
  output logic                                    disp_ready_o,
  input  logic                                    disp_has_dest_i,
  input  logic [AREG_W-1:0]                       disp_dest_reg_i,
  output logic [TAG_W-1:0]                        disp_tag_o,
  input  logic [WB_PORTS-1:0]                     wb_valid_i,
  input  logic [WB_PORTS-1:0][TAG_W-1:0]          wb_tag_i,
  input  logic [WB_PORTS-1:0][31:0]               wb_result_i,
  input  logic                                    flush_i,
  output logic [RETIRE_WIDTH-1:0]                 retire_valid_o,
  output logic [RETIRE_WIDTH-1:0][AREG_W-1:0]     retire_dest_reg_o,
  output logic [RETIRE_WIDTH-1:0][31:0]           retire_result_o,
  output logic [CNT_W-1:0]                        retire_count_o,
  output logic                                    rob_empty_o
);

  localparam int PTR_W = TAG_W + 1;

  // Handshakes: a dispatch is accepted on a cycle where disp_valid_i && disp_ready_o
  // are both high at the rising edge; writeback strobes and retire outputs are
  // single-cycle qualifiers with no backpressure.

  logic [ROB_DEPTH-1:0] busy_q, busy_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic [ROB_DEPTH-1:0] has_dest_q, has_dest_d;
  logic [AREG_W-1:0]    dest_q   [ROB_DEPTH];
  logic [AREG_W-1:0]    dest_d   [ROB_DEPTH];
  logic [31:0]          result_q [ROB_DEPTH];
  logic [31:0]          result_d [ROB_DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;

  logic [PTR_W-1:0]     count;
  logic [CNT_W-1:0]     ret_cnt;
  logic [ROB_DEPTH-1:0] ret_mask;
  logic [TAG_W-1:0]     ret_idx;
  logic                 chain;

  assign count        = tail_q - head_q;
  assign disp_ready_o = (count != PTR_W'(ROB_DEPTH));
  assign disp_tag_o   = tail_q[TAG_W-1:0];
  assign rob_empty_o  = (count == '0);

  // Walk from the head; the chain breaks at the first entry that is not done.
  always_comb begin
    ret_cnt           = '0;
    ret_mask          = '0;
    ret_idx           = '0;
    chain             = 1'b1;
    retire_valid_o    = '0;
    retire_dest_reg_o = '0;
    retire_result_o   = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      ret_idx = head_q[TAG_W-1:0] + TAG_W'(k);
      chain   = chain && busy_q[ret_idx] && done_q[ret_idx];
      if (chain) begin
        ret_cnt           = ret_cnt + CNT_W'(1);
        ret_mask[ret_idx] = 1'b1;
        if (has_dest_q[ret_idx] && (dest_q[ret_idx] != '0)) begin
          retire_valid_o[k]    = 1'b1;
          retire_dest_reg_o[k] = dest_q[ret_idx];
          retire_result_o[k]   = result_q[ret_idx];
        end
      end
    end
    if (flush_i) begin
      ret_cnt           = '0;
      retire_valid_o    = '0;
      retire_dest_reg_o = '0;
      retire_result_o   = '0;
    end
  end

  assign retire_count_o = ret_cnt;

  always_comb begin
    busy_d     = busy_q;
    done_d     = done_q;
    has_dest_d = has_dest_q;
    dest_d     = dest_q;
    result_d   = result_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (flush_i) begin
      busy_d = '0;
      done_d = '0;
      head_d = '0;
      tail_d = '0;
    end else begin
      busy_d = busy_d & ~ret_mask;
      done_d = done_d & ~ret_mask;
      head_d = head_q + PTR_W'(ret_cnt);
      // Highest port first so that port 0 overwrites on a shared tag.
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && busy_q[wb_tag_i[p]] && !done_q[wb_tag_i[p]]) begin
          done_d[wb_tag_i[p]]   = 1'b1;
          result_d[wb_tag_i[p]] = wb_result_i[p];
        end
      end
      if (disp_valid_i && disp_ready_o) begin
        busy_d[tail_q[TAG_W-1:0]]     = 1'b1;
        done_d[tail_q[TAG_W-1:0]]     = 1'b0;
        has_dest_d[tail_q[TAG_W-1:0]] = disp_has_dest_i;
        dest_d[tail_q[TAG_W-1:0]]     = disp_dest_reg_i;
        tail_d                        = tail_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q     <= '0;
      done_q     <= '0;
      has_dest_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        dest_q[i]   <= '0;
        result_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      has_dest_q <= has_dest_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        dest_q[i]   <= dest_d[i];
        result_q[i] <= result_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, corner-case sequences, and
// randomized traffic checked against a queue-based program-order model.
module tb_reorder_buffer;

  localparam int DEPTH = 32;
  localparam int RW    = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 disp_valid;
  logic                 disp_ready;
  logic                 disp_has_dest;
  logic [4:0]           disp_dest_reg;
  logic [4:0]           disp_tag;
  logic [1:0]           wb_valid;
  logic [1:0][4:0]      wb_tag;
  logic [1:0][31:0]     wb_result;
  logic                 flush;
  logic [1:0]           retire_valid;
  logic [1:0][4:0]      retire_dest_reg;
  logic [1:0][31:0]     retire_result;
  logic [1:0]           retire_count;
  logic                 rob_empty;

  int n_cmp  = 0;
  int n_fail = 0;

  reorder_buffer dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .disp_valid_i      (disp_valid),
    .disp_ready_o      (disp_ready),
    .disp_has_dest_i   (disp_has_dest),
    .disp_dest_reg_i   (disp_dest_reg),
    .disp_tag_o        (disp_tag),
    .wb_valid_i        (wb_valid),
    .wb_tag_i          (wb_tag),
    .wb_result_i       (wb_result),
    .flush_i           (flush),
    .retire_valid_o    (retire_valid),
    .retire_dest_reg_o (retire_dest_reg),
    .retire_result_o   (retire_result),
    .retire_count_o    (retire_count),
    .rob_empty_o       (rob_empty)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: live instructions in program order
  typedef struct {
    logic        has_dest;
    logic [4:0]  dest;
    logic        done;
    logic [31:0] res;
    int          tag;
  } ent_t;
  ent_t mq[$];
  int   m_tail;

  typedef struct {
    logic dv; logic hd; logic [4:0] dr;
    logic w0v; logic [4:0] w0t; logic [31:0] w0r;
    logic w1v; logic [4:0] w1t; logic [31:0] w1r;
    logic e_rdy; logic [4:0] e_tag; logic e_emp; logic [1:0] e_cnt; logic [1:0] e_rv;
    logic [4:0] e_rd0; logic [31:0] e_rr0; logic [4:0] e_rd1; logic [31:0] e_rr1;
  } vec_t;
  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    disp_valid    = 1'b0;
    disp_has_dest = 1'b0;
    disp_dest_reg = '0;
    wb_valid      = '0;
    wb_tag        = '0;
    wb_result     = '0;
    flush         = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", {31'd0, disp_ready}, 32'd1);
    chk("rst_tag", {27'd0, disp_tag}, 32'd0);
    chk("rst_empty", {31'd0, rob_empty}, 32'd1);
    chk("rst_rv", {30'd0, retire_valid}, 32'd0);
    chk("rst_cnt", {30'd0, retire_count}, 32'd0);
    chk("rst_rd", {22'd0, retire_dest_reg}, 32'd0);
    chk("rst_rr0", retire_result[0], 32'd0);
    chk("rst_rr1", retire_result[1], 32'd0);
  endtask

  // Compare outputs against the model, advance the model, and take one edge.
  task automatic cycle();
    int  n;
    bit  e_rdy;
    bit  pre_done[DEPTH];
    bit  wr[DEPTH];
    ent_t e;
    #1;
    e_rdy = (mq.size() < DEPTH);
    n = 0;
    for (int k = 0; k < RW; k++)
      if (k < mq.size() && n == k && mq[k].done) n++;
    chk("m_ready", {31'd0, disp_ready}, {31'd0, e_rdy});
    chk("m_tag", {27'd0, disp_tag}, m_tail);
    chk("m_empty", {31'd0, rob_empty}, {31'd0, mq.size() == 0});
    chk("m_cnt", {30'd0, retire_count}, flush ? 0 : n);
    for (int k = 0; k < RW; k++) begin
      bit ev;
      ev = !flush && (k < n) && mq[k].has_dest && (mq[k].dest != 0);
      chk("m_rv", {31'd0, retire_valid[k]}, {31'd0, ev});
      if (ev) begin
        chk("m_rd", {27'd0, retire_dest_reg[k]}, {27'd0, mq[k].dest});
        chk("m_rr", retire_result[k], mq[k].res);
      end
    end
    if (flush) begin
      model_reset();
    end else begin
      for (int i = 0; i < mq.size(); i++) begin
        pre_done[i] = mq[i].done;
        wr[i] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p]) begin
          for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == int'(wb_tag[p]) && !pre_done[i] && !wr[i]) begin
              e = mq[i];
              e.done = 1'b1;
              e.res = wb_result[p];
              mq[i] = e;
              wr[i] = 1'b1;
            end
          end
        end
      end
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      if (disp_valid && e_rdy) begin
        e.has_dest = disp_has_dest;
        e.dest = disp_dest_reg;
        e.done = 1'b0;
        e.res = '0;
        e.tag = m_tail;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic hd, input logic [4:0] dr);
    idle_inputs();
    disp_valid = 1'b1;
    disp_has_dest = hd;
    disp_dest_reg = dr;
    cycle();
  endtask

  task automatic wb2(input logic v0, input int t0, input logic [31:0] r0,
                     input logic v1, input int t1, input logic [31:0] r1);
    idle_inputs();
    wb_valid = {v1, v0};
    wb_tag[0] = 5'(t0);
    wb_tag[1] = 5'(t1);
    wb_result[0] = r0;
    wb_result[1] = r1;
    cycle();
  endtask

  initial begin
    int head_tag;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;

    vt[0]  = '{1,1,1,  0,0,0,        0,0,0,     1,0,1,0,2'b00, 0,0,0,0};
    vt[1]  = '{1,1,2,  0,0,0,        0,0,0,     1,1,0,0,2'b00, 0,0,0,0};
    vt[2]  = '{1,1,3,  0,0,0,        0,0,0,     1,2,0,0,2'b00, 0,0,0,0};
    vt[3]  = '{0,0,0,  1,2,32'h30,   0,0,0,     1,3,0,0,2'b00, 0,0,0,0};
    vt[4]  = '{0,0,0,  1,0,32'h10,   1,1,32'h20,1,3,0,0,2'b00, 0,0,0,0};
    vt[5]  = '{0,0,0,  0,0,0,        0,0,0,     1,3,0,2,2'b11, 1,32'h10,2,32'h20};
    vt[6]  = '{0,0,0,  0,0,0,        0,0,0,     1,3,0,1,2'b01, 3,32'h30,0,0};
    vt[7]  = '{1,1,0,  0,0,0,        0,0,0,     1,3,1,0,2'b00, 0,0,0,0};
    vt[8]  = '{1,0,5,  0,0,0,        0,0,0,     1,4,0,0,2'b00, 0,0,0,0};
    vt[9]  = '{0,0,0,  1,3,32'hDEAD, 1,4,32'h1, 1,5,0,0,2'b00, 0,0,0,0};
    vt[10] = '{0,0,0,  0,0,0,        0,0,0,     1,5,0,2,2'b00, 0,0,0,0};
    vt[11] = '{1,1,7,  0,0,0,        0,0,0,     1,5,1,0,2'b00, 0,0,0,0};
    vt[12] = '{0,0,0,  1,5,32'hA,    1,5,32'hB, 1,6,0,0,2'b00, 0,0,0,0};
    vt[13] = '{0,0,0,  0,0,0,        0,0,0,     1,6,0,1,2'b01, 7,32'hA,0,0};
    vt[14] = '{0,0,0,  0,0,0,        0,0,0,     1,6,1,0,2'b00, 0,0,0,0};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table: in-order completion, x0/no-dest, shared tag
    for (int i = 0; i < 15; i++) begin
      idle_inputs();
      disp_valid = vt[i].dv; disp_has_dest = vt[i].hd; disp_dest_reg = vt[i].dr;
      wb_valid = {vt[i].w1v, vt[i].w0v};
      wb_tag[0] = vt[i].w0t; wb_tag[1] = vt[i].w1t;
      wb_result[0] = vt[i].w0r; wb_result[1] = vt[i].w1r;
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, disp_ready}, {31'd0, vt[i].e_rdy});
      chk($sformatf("v%0d_tag", i), {27'd0, disp_tag}, {27'd0, vt[i].e_tag});
      chk($sformatf("v%0d_empty", i), {31'd0, rob_empty}, {31'd0, vt[i].e_emp});
      chk($sformatf("v%0d_cnt", i), {30'd0, retire_count}, {30'd0, vt[i].e_cnt});
      chk($sformatf("v%0d_rv", i), {30'd0, retire_valid}, {30'd0, vt[i].e_rv});
      if (vt[i].e_rv[0]) begin
        chk($sformatf("v%0d_rd0", i), {27'd0, retire_dest_reg[0]}, {27'd0, vt[i].e_rd0});
        chk($sformatf("v%0d_rr0", i), retire_result[0], vt[i].e_rr0);
      end
      if (vt[i].e_rv[1]) begin
        chk($sformatf("v%0d_rd1", i), {27'd0, retire_dest_reg[1]}, {27'd0, vt[i].e_rd1});
        chk($sformatf("v%0d_rr1", i), retire_result[1], vt[i].e_rr1);
      end
      cycle();
    end

    // Fill to capacity, attempt an extra dispatch, then free one slot across the wrap
    for (int i = 0; i < DEPTH; i++) dispatch(1'b1, 5'($urandom_range(1, 31)));
    idle_inputs();
    disp_valid = 1'b1; disp_has_dest = 1'b1; disp_dest_reg = 5'd9;
    #1;
    chk("full_ready", {31'd0, disp_ready}, 32'd0);
    cycle();
    head_tag = mq[0].tag;
    wb2(1'b1, head_tag, 32'h5555, 1'b0, 0, 0);
    idle_inputs();
    disp_valid = 1'b1; disp_has_dest = 1'b1; disp_dest_reg = 5'd9;
    #1;
    chk("retire_cycle_ready", {31'd0, disp_ready}, 32'd0);
    chk("retire_cycle_cnt", {30'd0, retire_count}, 32'd1);
    cycle();
    idle_inputs();
    disp_valid = 1'b1; disp_has_dest = 1'b1; disp_dest_reg = 5'd9;
    #1;
    chk("after_retire_ready", {31'd0, disp_ready}, 32'd1);
    chk("wrap_tag", {27'd0, disp_tag}, head_tag);
    cycle();
    idle_inputs();
    flush = 1'b1;
    cycle();

    // Flush with live entries, some done and the head chain eligible
    for (int i = 0; i < 10; i++) dispatch(1'b1, 5'(i + 1));
    wb2(1'b1, 1, 32'h11, 1'b1, 2, 32'h22);
    wb2(1'b1, 0, 32'h00, 1'b1, 3, 32'h33);
    idle_inputs();
    flush = 1'b1;
    #1;
    chk("flush_rv", {30'd0, retire_valid}, 32'd0);
    chk("flush_cnt", {30'd0, retire_count}, 32'd0);
    cycle();
    idle_inputs();
    wb_valid = 2'b01; wb_tag[0] = 5'd2; wb_result[0] = 32'hBAD;
    #1;
    chk("post_flush_empty", {31'd0, rob_empty}, 32'd1);
    chk("post_flush_rv", {30'd0, retire_valid}, 32'd0);
    cycle();
    idle_inputs();
    #1;
    chk("stale_wb_empty", {31'd0, rob_empty}, 32'd1);
    chk("stale_wb_cnt", {30'd0, retire_count}, 32'd0);
    cycle();

    // Asynchronous reset with five live entries
    for (int i = 0; i < 5; i++) dispatch(1'b1, 5'(i + 3));
    wb2(1'b1, 1, 32'h77, 1'b1, 2, 32'h88);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      disp_valid    = ($urandom_range(0, 99) < 60);
      disp_has_dest = ($urandom_range(0, 9) != 0);
      disp_dest_reg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      for (int p = 0; p < 2; p++) begin
        wb_valid[p]  = ($urandom_range(0, 99) < 45);
        wb_result[p] = $urandom;
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          wb_tag[p] = 5'(mq[$urandom_range(0, mq.size() - 1)].tag);
        else
          wb_tag[p] = 5'($urandom_range(0, DEPTH - 1));
      end
      if ($urandom_range(0, 15) == 0) wb_tag[1] = wb_tag[0];
      flush = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
